bip_control_unit: RTL and testbench

Instruction-sequencing block for the BIP processor. It fetches 16-bit instructions from the synchronous program memory, decodes the 5-bit opcode, and drives the datapath control inputs: mux selectors, accumulator enable, ALU operation, operand, and data-RAM read/write strobes. It is the initiator side of the datapath control interface and owns the program counter, the fetch/execute FSM and the halt condition.

---
 rtl/bip_control_unit.sv | 181 ++++++++++++++++++
 tb/tb_bip_control_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// -----------------------------------------------------------------------------
// bip_control_unit
//
// Instruction sequencer for the BIP processor. Owns the program counter, the
// FETCH/EXECUTE/HALT state machine, a saturating retired-instruction counter,
// and decodes the 5-bit opcode into the datapath control vector.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        asynchronous, active-low reset
//   i_enable       run gate; low stalls state, PC and counter
//   i_instruction  program-memory read data (valid one cycle after o_pc)
//   o_pc           program-memory address (registered)
//   o_operand      i_instruction[10:0], combinational pass-through
//   o_sel_a        datapath mux A: 00 RAM, 01 sign-extended operand, 10 ALU
//   o_sel_b        ALU B input: 0 RAM data, 1 sign-extended operand
//   o_enb_acc      accumulator write enable
//   o_operation    ALU op: 0 add, 1 subtract
//   o_rd_ram       data-RAM read strobe
//   o_wr_ram       data-RAM write strobe
//   o_halted       high while in HALT
//   o_instr_count  retired instructions, saturating
// -----------------------------------------------------------------------------
module bip_control_unit #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11,
    parameter int NB_OPCODE      = 5,
    parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
    parameter int NB_SELECTOR_A  = 2,
    parameter int NB_COUNT       = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [NB_INSTRUCTION-1:0] i_instruction,
    output logic [NB_ADDR-1:0]        o_pc,
    output logic [NB_OPERAND-1:0]     o_operand,
    output logic [NB_SELECTOR_A-1:0]  o_sel_a,
    output logic                      o_sel_b,
    output logic                      o_enb_acc,
    output logic                      o_operation,
    output logic                      o_rd_ram,
    output logic                      o_wr_ram,
    output logic                      o_halted,
    output logic [NB_COUNT-1:0]       o_instr_count
);

    localparam logic [NB_OPCODE-1:0] OP_HLT  = 5'b00000;
    localparam logic [NB_OPCODE-1:0] OP_STO  = 5'b00001;
    localparam logic [NB_OPCODE-1:0] OP_LD   = 5'b00010;
    localparam logic [NB_OPCODE-1:0] OP_LDI  = 5'b00011;
    localparam logic [NB_OPCODE-1:0] OP_ADD  = 5'b00100;
    localparam logic [NB_OPCODE-1:0] OP_ADDI = 5'b00101;
    localparam logic [NB_OPCODE-1:0] OP_SUB  = 5'b00110;
    localparam logic [NB_OPCODE-1:0] OP_SUBI = 5'b00111;

    localparam logic [NB_SELECTOR_A-1:0] SEL_A_RAM = 2'b00;
    localparam logic [NB_SELECTOR_A-1:0] SEL_A_IMM = 2'b01;
    localparam logic [NB_SELECTOR_A-1:0] SEL_A_ALU = 2'b10;

    localparam logic [NB_COUNT-1:0] COUNT_MAX = {NB_COUNT{1'b1}};

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NB_ADDR-1:0]   pc_q, pc_d;
    logic [NB_COUNT-1:0]  count_q, count_d;
    logic [NB_OPCODE-1:0] opcode;

    assign opcode = i_instruction[NB_INSTRUCTION-1 -: NB_OPCODE];

    // State register: PC, counter and state all share the async clear.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Next-state logic. Everything holds while i_enable is low.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            ST_FETCH: begin
                if (i_enable) begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (i_enable) begin
                    // Every executed opcode retires, HLT included.
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + NB_COUNT'(1);
                    end
                    if (opcode == OP_HLT) begin
                        state_d = ST_HALT;
                    end else begin
                        // Natural NB_ADDR-bit wrap 0x7FF -> 0x000.
                        pc_d    = pc_q + NB_ADDR'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Output decode. Controls are live only in an enabled EXECUTE cycle, so a
    // stalled EXECUTE or an asynchronous reset drops every strobe at once.
    always_comb begin
        o_sel_a     = SEL_A_RAM;
        o_sel_b     = 1'b0;
        o_enb_acc   = 1'b0;
        o_operation = 1'b0;
        o_rd_ram    = 1'b0;
        o_wr_ram    = 1'b0;
        if ((state_q == ST_EXECUTE) && i_enable) begin
            case (opcode)
                OP_STO: begin
                    o_wr_ram = 1'b1;
                end
                OP_LD: begin
                    o_rd_ram  = 1'b1;
                    o_sel_a   = SEL_A_RAM;
                    o_enb_acc = 1'b1;
                end
                OP_LDI: begin
                    o_sel_a   = SEL_A_IMM;
                    o_enb_acc = 1'b1;
                end
                OP_ADD: begin
                    o_rd_ram  = 1'b1;
                    o_sel_a   = SEL_A_ALU;
                    o_enb_acc = 1'b1;
                end
                OP_ADDI: begin
                    o_sel_a   = SEL_A_ALU;
                    o_sel_b   = 1'b1;
                    o_enb_acc = 1'b1;
                end
                OP_SUB: begin
                    o_rd_ram    = 1'b1;
                    o_sel_a     = SEL_A_ALU;
                    o_operation = 1'b1;
                    o_enb_acc   = 1'b1;
                end
                OP_SUBI: begin
                    o_sel_a     = SEL_A_ALU;
                    o_sel_b     = 1'b1;
                    o_operation = 1'b1;
                    o_enb_acc   = 1'b1;
                end
                default: begin
                    // HLT and NOP range 01000-11111 assert nothing.
                end
            endcase
        end
    end

    assign o_pc          = pc_q;
    assign o_instr_count = count_q;
    assign o_halted      = (state_q == ST_HALT);
    assign o_operand     = i_instruction[NB_OPERAND-1:0];

endmodule

// File: tb/tb_bip_control_unit.sv
module tb_bip_control_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] instr;
    logic [10:0] pc;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        enb_acc;
    logic        operation;
    logic        rd_ram;
    logic        wr_ram;
    logic        halted;
    logic [15:0] icount;

    int total = 0;
    int bad   = 0;

    bip_control_unit dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_enable      (en),
        .i_instruction (instr),
        .o_pc          (pc),
        .o_operand     (operand),
        .o_sel_a       (sel_a),
        .o_sel_b       (sel_b),
        .o_enb_acc     (enb_acc),
        .o_operation   (operation),
        .o_rd_ram      (rd_ram),
        .o_wr_ram      (wr_ram),
        .o_halted      (halted),
        .o_instr_count (icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program memory: data for address o_pc appears after the edge.
    logic [15:0] prog [0:2047];
    always @(posedge clk) instr <= prog[pc];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Control vector {sel_a, sel_b, op, enb_acc, rd_ram, wr_ram} per opcode.
    function automatic logic [6:0] decode(input logic [4:0] opc);
        logic [6:0] tbl [0:7];
        tbl[0] = 7'b00_0_0_0_0_0; // HLT
        tbl[1] = 7'b00_0_0_0_0_1; // STO
        tbl[2] = 7'b00_0_0_1_1_0; // LD
        tbl[3] = 7'b01_0_0_1_0_0; // LDI
        tbl[4] = 7'b10_0_0_1_1_0; // ADD
        tbl[5] = 7'b10_1_0_1_0_0; // ADDI
        tbl[6] = 7'b10_0_1_1_1_0; // SUB
        tbl[7] = 7'b10_1_1_1_0_0; // SUBI
        if (opc < 5'd8) return tbl[opc[2:0]];
        return 7'b0;
    endfunction

    // Reference model: an instruction spends one enabled cycle being fetched
    // and one being executed; a halted machine does nothing further.
    bit m_second_half;
    bit m_halted;
    int m_pc;
    int m_count;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_second_half <= 0;
            m_halted      <= 0;
            m_pc          <= 0;
            m_count       <= 0;
        end else if (!m_halted && en) begin
            if (!m_second_half) begin
                m_second_half <= 1;
            end else begin
                m_second_half <= 0;
                m_count <= (m_count == 65535) ? 65535 : m_count + 1;
                if (instr[15:11] == 5'd0) m_halted <= 1;
                else                      m_pc <= (m_pc + 1) % 2048;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [6:0] exp_ctrl;
        exp_ctrl = (rst_n && en && m_second_half && !m_halted) ? decode(instr[15:11]) : 7'b0;
        check("ctrl",    {25'd0, sel_a, sel_b, operation, enb_acc, rd_ram, wr_ram}, {25'd0, exp_ctrl});
        check("operand", {21'd0, operand}, {21'd0, instr[10:0]});
        check("pc",      {21'd0, pc}, m_pc);
        check("count",   {16'd0, icount}, m_count);
        check("halted",  {31'd0, halted}, {31'd0, m_halted});
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        edges(2);
        rst_n = 1'b1;
    endtask

    task automatic fill(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) prog[i] = w;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        fill(16'h4000);
        #1;
        // Reset-state pins.
        #3;
        check("rst_pc",     {21'd0, pc}, 32'd0);
        check("rst_count",  {16'd0, icount}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // Program: LDI 5; ADDI 3; STO 0x010; HLT.
        $display("test 1: LDI/ADDI/STO/HLT program");
        prog[0] = {5'b00011, 11'd5};
        prog[1] = {5'b00101, 11'd3};
        prog[2] = {5'b00001, 11'h010};
        prog[3] = {5'b00000, 11'd0};
        do_reset();
        edges(5);
        check("sto_wr",      {31'd0, wr_ram}, 32'd1);
        check("sto_operand", {21'd0, operand}, 32'h010);
        edges(2);
        check("halt_not_yet", {31'd0, halted}, 32'd0);
        edges(1);
        check("halt_at_8", {31'd0, halted}, 32'd1);
        check("final_pc",  {21'd0, pc}, 32'd3);
        check("final_cnt", {16'd0, icount}, 32'd4);
        $display("test 1b: 100 enabled cycles in HALT");
        edges(100);
        check("halt_pc",  {21'd0, pc}, 32'd3);
        check("halt_cnt", {16'd0, icount}, 32'd4);
        check("halt_hi",  {31'd0, halted}, 32'd1);
        check("halt_ctl", {27'd0, enb_acc, rd_ram, wr_ram, sel_b, operation}, 32'd0);

        // Decode sweep over opcodes 1..7, then HLT.
        $display("test 2: decode sweep");
        fill(16'h4000);
        for (int k = 0; k < 7; k++) prog[k] = {5'(k + 1), 11'(k * 3 + 1)};
        prog[7] = 16'h0000;
        do_reset();
        edges(13);
        check("subi_vec", {25'd0, sel_a, sel_b, operation, enb_acc, rd_ram, wr_ram}, {25'd0, 7'b10_1_1_1_0_0});
        edges(3);
        check("sweep_cnt", {16'd0, icount}, 32'd8);
        check("sweep_pc",  {21'd0, pc}, 32'd7);

        // ADD with i_enable low for three EXECUTE cycles.
        $display("test 3: stalled ADD");
        fill(16'h0000);
        prog[0] = {5'b00100, 11'h005};
        do_reset();
        edges(1);
        en = 1'b0;
        #1;
        check("stall_enb", {31'd0, enb_acc}, 32'd0);
        check("stall_rd",  {31'd0, rd_ram}, 32'd0);
        edges(3);
        check("stall_pc",  {21'd0, pc}, 32'd0);
        check("stall_cnt", {16'd0, icount}, 32'd0);
        en = 1'b1;
        #1;
        check("add_vec", {25'd0, sel_a, sel_b, operation, enb_acc, rd_ram, wr_ram}, {25'd0, 7'b10_0_0_1_1_0});
        edges(1);
        check("add_pc",  {21'd0, pc}, 32'd1);
        check("add_cnt", {16'd0, icount}, 32'd1);

        // 2048 NOPs: PC wraps, counter reaches 2048.
        $display("test 4: 2048 NOPs");
        fill(16'h4000);
        do_reset();
        edges(4094);
        check("nop_pc_max", {21'd0, pc}, 32'h7FF);
        check("nop_cnt_a",  {16'd0, icount}, 32'd2047);
        edges(2);
        check("nop_pc_wrap", {21'd0, pc}, 32'd0);
        check("nop_cnt_b",   {16'd0, icount}, 32'd2048);

        // Reset mid-EXECUTE of STO.
        $display("test 5: reset during STO execute");
        fill(16'h4000);
        prog[1] = {5'b00001, 11'h010};
        do_reset();
        edges(3);
        check("pre_rst_wr",  {31'd0, wr_ram}, 32'd1);
        check("pre_rst_pc",  {21'd0, pc}, 32'd1);
        check("pre_rst_cnt", {16'd0, icount}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_wr",  {31'd0, wr_ram}, 32'd0);
        check("rst_pc2", {21'd0, pc}, 32'd0);
        check("rst_cnt", {16'd0, icount}, 32'd0);
        edges(1);
        rst_n = 1'b1;
        edges(1);
        check("post_pc",  {21'd0, pc}, 32'd0);
        check("post_cnt", {16'd0, icount}, 32'd0);
        edges(1);
        check("post_pc1",  {21'd0, pc}, 32'd1);
        check("post_cnt1", {16'd0, icount}, 32'd1);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
